// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: datapath widths and ALU/branch opcodes shared with the ALU and decoder
package id_ex_operand_stage_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [3:0] BR_BEQ  = 4'b1000;
    localparam logic [3:0] BR_BNE  = 4'b1001;
    localparam logic [3:0] BR_BLT  = 4'b1100;
    localparam logic [3:0] BR_BGE  = 4'b1101;
    localparam logic [3:0] BR_BLTU = 4'b1110;
    localparam logic [3:0] BR_BGEU = 4'b1111;
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: decode-side capture bus and ALU-side handshake of the ID/EX stage
interface id_ex_operand_stage_if
    import id_ex_operand_stage_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              iFlush, iValid, oReady;
    logic [REG_AW-1:0] iRs1Addr, iRs2Addr, iRdAddr;
    logic [XLEN-1:0]   iRs1Data, iRs2Data, iImm, iPc;
    logic [3:0]        iAluOp;
    logic              iUseImm, iUsePcA, iRegWrite, iIsBranch;
    logic              iExFwdValid, iMemFwdValid;
    logic [REG_AW-1:0] iExFwdAddr, iMemFwdAddr;
    logic [XLEN-1:0]   iExFwdData, iMemFwdData;
    logic              iLoadPend;
    logic [REG_AW-1:0] iLoadPendRd;
    logic              oValid, iReady;
    logic [XLEN-1:0]   oDataA, oDataB, oStoreData, oPc;
    logic [3:0]        oAluOp;
    logic [REG_AW-1:0] oRdAddr;
    logic              oRegWrite, oIsBranch;
    logic [CNT_W-1:0]  oStallCnt;

    modport master (
        output iFlush, iValid, iRs1Addr, iRs2Addr, iRs1Data, iRs2Data, iImm, iPc, iAluOp,
               iUseImm, iUsePcA, iRdAddr, iRegWrite, iIsBranch, iExFwdValid, iExFwdAddr,
               iExFwdData, iMemFwdValid, iMemFwdAddr, iMemFwdData, iLoadPend, iLoadPendRd, iReady,
        input  oReady, oValid, oDataA, oDataB, oAluOp, oStoreData, oPc, oRdAddr, oRegWrite,
               oIsBranch, oStallCnt
    );

    modport slave (
        input  iFlush, iValid, iRs1Addr, iRs2Addr, iRs1Data, iRs2Data, iImm, iPc, iAluOp,
               iUseImm, iUsePcA, iRdAddr, iRegWrite, iIsBranch, iExFwdValid, iExFwdAddr,
               iExFwdData, iMemFwdValid, iMemFwdAddr, iMemFwdData, iLoadPend, iLoadPendRd, iReady,
        output oReady, oValid, oDataA, oDataB, oAluOp, oStoreData, oPc, oRdAddr, oRegWrite,
               oIsBranch, oStallCnt
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// fwd_mux: resolves one source register through EX/MEM then MEM/WB forwarding; x0 reads as zero
module fwd_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] rsAddr,
    input  logic [XLEN-1:0]   rsData,
    input  logic              exValid,
    input  logic [REG_AW-1:0] exAddr,
    input  logic [XLEN-1:0]   exData,
    input  logic              memValid,
    input  logic [REG_AW-1:0] memAddr,
    input  logic [XLEN-1:0]   memData,
    output logic [XLEN-1:0]   fwdData
);
    assign fwdData = (rsAddr == '0) ? '0 :
                     (exValid && exAddr == rsAddr) ? exData :
                     (memValid && memAddr == rsAddr) ? memData : rsData;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding/select,
// valid/ready handshake, load-use blocking and a saturating stall counter
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic iClk,
    input logic iRstN,
    id_ex_operand_stage_if.slave bus
);
    logic            hazard, accept;
    logic [XLEN-1:0] fwdRs1, fwdRs2;

    assign hazard = bus.iLoadPend && bus.iLoadPendRd != '0 &&
                    (bus.iLoadPendRd == bus.iRs1Addr || bus.iLoadPendRd == bus.iRs2Addr);
    // gated by iRstN so decode never sees a handshake while the stage is held in reset
    assign bus.oReady = iRstN && (!bus.oValid || bus.iReady) && !hazard;
    assign accept = bus.iValid && bus.oReady;

    fwd_mux fwdRs1Mux (
        .rsAddr(bus.iRs1Addr), .rsData(bus.iRs1Data),
        .exValid(bus.iExFwdValid), .exAddr(bus.iExFwdAddr), .exData(bus.iExFwdData),
        .memValid(bus.iMemFwdValid), .memAddr(bus.iMemFwdAddr), .memData(bus.iMemFwdData),
        .fwdData(fwdRs1)
    );

    fwd_mux fwdRs2Mux (
        .rsAddr(bus.iRs2Addr), .rsData(bus.iRs2Data),
        .exValid(bus.iExFwdValid), .exAddr(bus.iExFwdAddr), .exData(bus.iExFwdData),
        .memValid(bus.iMemFwdValid), .memAddr(bus.iMemFwdAddr), .memData(bus.iMemFwdData),
        .fwdData(fwdRs2)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            bus.oValid     <= 1'b0;
            bus.oDataA     <= '0;
            bus.oDataB     <= '0;
            bus.oStoreData <= '0;
            bus.oPc        <= '0;
            bus.oAluOp     <= '0;
            bus.oRdAddr    <= '0;
            bus.oRegWrite  <= 1'b0;
            bus.oIsBranch  <= 1'b0;
            bus.oStallCnt  <= '0;
        end else begin
            bus.oValid <= !bus.iFlush && (accept || (bus.oValid && !bus.iReady));
            if (accept) begin
                bus.oDataA     <= bus.iUsePcA ? bus.iPc : fwdRs1;
                bus.oDataB     <= bus.iUseImm ? bus.iImm : fwdRs2;
                bus.oStoreData <= fwdRs2;
                bus.oPc        <= bus.iPc;
                bus.oAluOp     <= bus.iAluOp;
                bus.oRdAddr    <= bus.iRdAddr;
                bus.oRegWrite  <= bus.iRegWrite;
                bus.oIsBranch  <= bus.iIsBranch;
            end
            if (bus.iValid && hazard && !bus.iFlush && bus.oStallCnt != '1)
                bus.oStallCnt <= bus.oStallCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: vector table, directed corner sequences and random traffic
// checked against a transaction-level model of the ID/EX stage
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    localparam int CW = 4;

    logic clk, rstN;
    id_ex_operand_stage_if #(.CNT_W(CW)) bus ();
    id_ex_operand_stage #(.CNT_W(CW)) dut (.iClk(clk), .iRstN(rstN), .bus(bus));

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] a, b, st, pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw, br;
    } entry_t;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [3:0]  op;
        logic        useImm, usePcA;
        logic        exV;
        logic [4:0]  exA;
        logic [31:0] exD;
        logic        memV;
        logic [4:0]  memA;
        logic [31:0] memD;
        logic [31:0] expA, expB, expSt;
    } vec_t;

    entry_t m;
    int stallModel;
    int tests, fails;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 0;
        if (bus.iExFwdValid && bus.iExFwdAddr == a) return bus.iExFwdData;
        if (bus.iMemFwdValid && bus.iMemFwdAddr == a) return bus.iMemFwdData;
        return rf;
    endfunction

    task automatic clearIn();
        bus.iFlush = 0; bus.iValid = 0; bus.iReady = 1;
        bus.iRs1Addr = 0; bus.iRs2Addr = 0; bus.iRs1Data = 0; bus.iRs2Data = 0;
        bus.iImm = 0; bus.iPc = 0; bus.iAluOp = 0; bus.iUseImm = 0; bus.iUsePcA = 0;
        bus.iRdAddr = 0; bus.iRegWrite = 0; bus.iIsBranch = 0;
        bus.iExFwdValid = 0; bus.iExFwdAddr = 0; bus.iExFwdData = 0;
        bus.iMemFwdValid = 0; bus.iMemFwdAddr = 0; bus.iMemFwdData = 0;
        bus.iLoadPend = 0; bus.iLoadPendRd = 0;
    endtask

    task automatic checkOut();
        check("oValid", {31'b0, bus.oValid}, {31'b0, m.valid});
        check("oStallCnt", {{(32-CW){1'b0}}, bus.oStallCnt}, stallModel);
        if (m.valid) begin
            check("oDataA", bus.oDataA, m.a);
            check("oDataB", bus.oDataB, m.b);
            check("oStoreData", bus.oStoreData, m.st);
            check("oPc", bus.oPc, m.pc);
            check("oAluOp", {28'b0, bus.oAluOp}, {28'b0, m.op});
            check("oRdAddr", {27'b0, bus.oRdAddr}, {27'b0, m.rd});
            check("oRegWrite", {31'b0, bus.oRegWrite}, {31'b0, m.rw});
            check("oIsBranch", {31'b0, bus.oIsBranch}, {31'b0, m.br});
        end
    endtask

    // one clock: predict ready and next entry from the current inputs, clock, compare
    task automatic step();
        logic hz, rdy, take;
        entry_t n;
        #1;
        hz = bus.iLoadPend && bus.iLoadPendRd != 0 &&
             (bus.iLoadPendRd == bus.iRs1Addr || bus.iLoadPendRd == bus.iRs2Addr);
        rdy = (!m.valid || bus.iReady) && !hz;
        check("oReady", {31'b0, bus.oReady}, {31'b0, rdy});
        take = bus.iValid && rdy;
        n = m;
        if (take) begin
            n.a  = bus.iUsePcA ? bus.iPc : resolve(bus.iRs1Addr, bus.iRs1Data);
            n.st = resolve(bus.iRs2Addr, bus.iRs2Data);
            n.b  = bus.iUseImm ? bus.iImm : n.st;
            n.pc = bus.iPc; n.op = bus.iAluOp; n.rd = bus.iRdAddr;
            n.rw = bus.iRegWrite; n.br = bus.iIsBranch;
        end
        n.valid = !bus.iFlush && (take || (m.valid && !bus.iReady));
        if (bus.iValid && hz && !bus.iFlush && stallModel < 2**CW - 1) stallModel++;
        @(posedge clk);
        #1;
        m = n;
        checkOut();
    endtask

    task automatic midReset();
        #2;
        rstN = 0;
        #1;
        check("rstValid", {31'b0, bus.oValid}, 0);
        check("rstDataA", bus.oDataA, 0);
        check("rstDataB", bus.oDataB, 0);
        check("rstStall", {{(32-CW){1'b0}}, bus.oStallCnt}, 0);
        check("rstReady", {31'b0, bus.oReady}, 0);
        m = '{default: 0};
        stallModel = 0;
        @(posedge clk);
        #1;
        rstN = 1;
    endtask

    task automatic setOp(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                         input logic [31:0] d2, input logic [3:0] op, input logic br);
        bus.iRs1Addr = rs1; bus.iRs1Data = d1; bus.iRs2Addr = rs2; bus.iRs2Data = d2;
        bus.iAluOp = op; bus.iIsBranch = br; bus.iRegWrite = !br;
        bus.iRdAddr = br ? 5'd0 : 5'd9;
        bus.iPc = bus.iPc + 4;
    endtask

    initial begin
        tests = 0; fails = 0; stallModel = 0;
        m = '{default: 0};
        clearIn();
        rstN = 0;
        repeat (2) @(posedge clk);
        #1;
        check("resetValid", {31'b0, bus.oValid}, 0);
        check("resetStall", {{(32-CW){1'b0}}, bus.oStallCnt}, 0);
        rstN = 1;

        //           rs1 rs2 rs1d   rs2d  imm           pc      op  imm pcA exV exA exD    memV memA memD   expA    expB          expSt
        vecs[0] = '{1, 2, 10, 5, 0, 32'h40, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 10, 5, 5};
        vecs[1] = '{3, 0, 1, 99, 0, 32'h44, ALU_ADD, 0, 0, 1, 3, 7, 1, 3, 2, 7, 0, 0};
        vecs[2] = '{3, 0, 1, 99, 0, 32'h48, ALU_ADD, 0, 0, 0, 3, 7, 1, 3, 2, 2, 0, 0};
        vecs[3] = '{0, 0, 1, 1, 0, 32'h4c, ALU_ADD, 0, 0, 1, 0, 9, 1, 0, 9, 0, 0, 0};
        vecs[4] = '{1, 2, 10, 5, 32'hfffffffc, 32'h50, ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 10, 32'hfffffffc, 5};
        vecs[5] = '{1, 2, 10, 5, 32'h1000, 32'h100, ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 32'h100, 32'h1000, 5};
        vecs[6] = '{5, 6, 1, 2, 0, 32'h58, ALU_XOR, 0, 0, 1, 5, 32'hAA, 1, 6, 32'hBB, 32'hAA, 32'hBB, 32'hBB};
        vecs[7] = '{7, 7, 32'h11, 32'h11, 0, 32'h5c, ALU_OR, 0, 0, 1, 8, 32'h22, 0, 7, 32'h33, 32'h11, 32'h11, 32'h11};

        for (int i = 0; i < 8; i++) begin
            bus.iValid = 1; bus.iReady = 1;
            bus.iRs1Addr = vecs[i].rs1; bus.iRs2Addr = vecs[i].rs2;
            bus.iRs1Data = vecs[i].rs1d; bus.iRs2Data = vecs[i].rs2d;
            bus.iImm = vecs[i].imm; bus.iPc = vecs[i].pc; bus.iAluOp = vecs[i].op;
            bus.iUseImm = vecs[i].useImm; bus.iUsePcA = vecs[i].usePcA;
            bus.iExFwdValid = vecs[i].exV; bus.iExFwdAddr = vecs[i].exA; bus.iExFwdData = vecs[i].exD;
            bus.iMemFwdValid = vecs[i].memV; bus.iMemFwdAddr = vecs[i].memA; bus.iMemFwdData = vecs[i].memD;
            step();
            check("vecValid", {31'b0, bus.oValid}, 1);
            check("vecA", bus.oDataA, vecs[i].expA);
            check("vecB", bus.oDataB, vecs[i].expB);
            check("vecStore", bus.oStoreData, vecs[i].expSt);
            if (i == 0) check("aluSum", bus.oDataA + bus.oDataB, 15);
        end

        // load-use: rs2 waits on x4 for three cycles, then captures the forwarded load value
        clearIn();
        midReset();
        bus.iValid = 1; bus.iRs1Addr = 1; bus.iRs1Data = 3; bus.iRs2Addr = 4; bus.iRs2Data = 1;
        bus.iLoadPend = 1; bus.iLoadPendRd = 4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("luReady", {31'b0, bus.oReady}, 0);
            step();
        end
        check("luStall", {{(32-CW){1'b0}}, bus.oStallCnt}, 3);
        bus.iLoadPend = 0;
        bus.iExFwdValid = 1; bus.iExFwdAddr = 4; bus.iExFwdData = 32'h55;
        step();
        check("luDataB", bus.oDataB, 32'h55);

        // backpressure then flush
        clearIn();
        bus.iValid = 1; bus.iRs1Addr = 2; bus.iRs1Data = 32'hdead; bus.iRs2Addr = 3; bus.iRs2Data = 32'hbeef;
        bus.iPc = 32'h200; bus.iRdAddr = 6; bus.iRegWrite = 1;
        step();
        bus.iReady = 0;
        bus.iRs1Data = 32'h1234; bus.iRs2Data = 32'h5678; bus.iPc = 32'h204;
        repeat (2) begin
            step();
            check("holdA", bus.oDataA, 32'hdead);
            check("holdB", bus.oDataB, 32'hbeef);
            check("holdPc", bus.oPc, 32'h200);
        end
        bus.iReady = 1; bus.iFlush = 1;
        step();
        check("flushValid", {31'b0, bus.oValid}, 0);

        // flush during a hazard neither captures nor counts
        bus.iLoadPend = 1; bus.iLoadPendRd = 2;
        step();
        bus.iFlush = 0;
        step();

        // back-to-back: four ops with no bubble
        clearIn();
        bus.iValid = 1;
        setOp(1, 20, 2, 7, ALU_SUB, 0);
        step();
        check("b2bA0", bus.oDataA, 20); check("b2bB0", bus.oDataB, 7);
        check("b2bV0", {31'b0, bus.oValid}, 1);
        setOp(3, 32'hfffffffe, 4, 9, ALU_SLT, 0);
        step();
        check("b2bA1", bus.oDataA, 32'hfffffffe); check("b2bV1", {31'b0, bus.oValid}, 1);
        setOp(5, 5, 6, 5, BR_BGEU, 1);
        step();
        check("b2bOp2", {28'b0, bus.oAluOp}, {28'b0, BR_BGEU});
        check("b2bBr2", {31'b0, bus.oIsBranch}, 1); check("b2bV2", {31'b0, bus.oValid}, 1);
        setOp(7, 32'hf0, 8, 32'h3c, ALU_AND, 0);
        step();
        check("b2bB3", bus.oDataB, 32'h3c); check("b2bV3", {31'b0, bus.oValid}, 1);
        bus.iValid = 0;
        step();

        // stall counter saturation
        midReset();
        clearIn();
        bus.iValid = 1; bus.iRs1Addr = 5; bus.iLoadPend = 1; bus.iLoadPendRd = 5;
        repeat (2**CW + 4) step();
        check("stallSat", {{(32-CW){1'b0}}, bus.oStallCnt}, 2**CW - 1);

        // random traffic against the model
        midReset();
        for (int i = 0; i < 400; i++) begin
            bus.iValid = $urandom_range(0, 3) != 0;
            bus.iReady = $urandom_range(0, 3) != 0;
            bus.iFlush = $urandom_range(0, 15) == 0;
            bus.iRs1Addr = 5'($urandom_range(0, 7)); bus.iRs2Addr = 5'($urandom_range(0, 7));
            bus.iRs1Data = $urandom; bus.iRs2Data = $urandom; bus.iImm = $urandom; bus.iPc = $urandom;
            bus.iAluOp = 4'($urandom); bus.iUseImm = 1'($urandom); bus.iUsePcA = 1'($urandom);
            bus.iRdAddr = 5'($urandom); bus.iRegWrite = 1'($urandom); bus.iIsBranch = 1'($urandom);
            bus.iExFwdValid = 1'($urandom); bus.iExFwdAddr = 5'($urandom_range(0, 7)); bus.iExFwdData = $urandom;
            bus.iMemFwdValid = 1'($urandom); bus.iMemFwdAddr = 5'($urandom_range(0, 7)); bus.iMemFwdData = $urandom;
            bus.iLoadPend = $urandom_range(0, 3) == 0; bus.iLoadPendRd = 5'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
